// File: rtl/seq_decoder.sv
// Sequenced instruction decoder: latches an instruction, steps through operand
// cycles, fires one execution-unit start strobe and waits for done or timeout.
module seq_decoder #(
  parameter int DATA_W       = 16,
  parameter int OP_W         = 4,
  parameter int FIELD_W      = 6,
  parameter int IDX_W        = 4,
  parameter int IMM_SIGN_EXT = 0,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] instruction,
  output logic              ready,
  output logic [OP_W-1:0]   op_code,
  output logic [IDX_W-1:0]  index,
  output logic              iri_en,
  output logic              irj_en,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_out,
  output logic              alu_start,
  output logic              mov_start,
  output logic              ldsr_start,
  input  logic              exec_done,
  output logic              illegal,
  output logic              timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_OPA    = 3'd2;
  localparam logic [2:0] S_OPB    = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OP_W-1:0]    opcode;
  logic [FIELD_W-1:0] field_i, field_j;
  logic [31:0]        op_ext;
  logic [DATA_W-1:0]  imm_ext;
  logic               is_alu_rr, is_mov, is_addi, is_ldsr, is_illegal;
  logic               wait_expired;
  logic               unused_field_i;

  assign opcode  = ir_q[DATA_W-1 -: OP_W];
  assign field_i = ir_q[2*FIELD_W-1 -: FIELD_W];
  assign field_j = ir_q[FIELD_W-1:0];
  assign op_ext  = 32'(opcode);
  // Only the low IDX_W bits of field i ever reach an output.
  assign unused_field_i = ^field_i;

  assign is_alu_rr  = (op_ext <= 32'd5);
  assign is_mov     = (op_ext == 32'd6);
  assign is_addi    = (op_ext == 32'd7);
  assign is_ldsr    = (op_ext == 32'd8);
  assign is_illegal = (op_ext > 32'd8);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm
    if (gi < FIELD_W) begin : g_field
      assign imm_ext[gi] = field_j[gi];
    end else begin : g_ext
      assign imm_ext[gi] = (IMM_SIGN_EXT != 0) ? field_j[FIELD_W-1] : 1'b0;
    end
  end

  // Timeout is a pure state decode so no input reaches an output combinationally.
  assign wait_expired = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ir_load) begin
          ir_d    = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_illegal ? S_IDLE : S_OPA;
      S_OPA:    state_d = S_OPB;
      S_OPB:    state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done || wait_expired) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ready      = (state_q == S_IDLE);
    op_code    = (state_q == S_IDLE) ? '0 : opcode;
    index      = '0;
    iri_en     = 1'b0;
    irj_en     = 1'b0;
    bus_oe     = 1'b0;
    bus_out    = '0;
    alu_start  = 1'b0;
    mov_start  = 1'b0;
    ldsr_start = 1'b0;
    illegal    = (state_q == S_DECODE) && is_illegal;
    timeout    = wait_expired;
    if (state_q == S_OPA) begin
      iri_en = 1'b1;
      index  = field_i[IDX_W-1:0];
    end
    if (state_q == S_OPB) begin
      if (is_addi) begin
        bus_oe  = 1'b1;
        bus_out = imm_ext;
      end else begin
        irj_en = 1'b1;
        index  = field_j[IDX_W-1:0];
      end
    end
    if (state_q == S_START) begin
      alu_start  = is_alu_rr || is_addi;
      mov_start  = is_mov;
      ldsr_start = is_ldsr;
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: two instances (zero- and sign-extending
// immediates) compared every cycle against a timeline model of each instruction.
module tb_seq_decoder;
  localparam int T = 16;

  typedef struct packed {
    logic        ready;
    logic [3:0]  op;
    logic [3:0]  idx;
    logic        iri;
    logic        irj;
    logic        boe;
    logic [15:0] bus;
    logic        alu;
    logic        mov;
    logic        ldsr;
    logic        ill;
    logic        tmo;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, ir_load, exec_done;
  logic [15:0] instruction;

  logic        rdy0, iri0, irj0, boe0, alu0, mov0, ldsr0, ill0, tmo0;
  logic [3:0]  op0, idx0;
  logic [15:0] bus0;
  logic        rdy1, iri1, irj1, boe1, alu1, mov1, ldsr1, ill1, tmo1;
  logic [3:0]  op1, idx1;
  logic [15:0] bus1;

  obs_t act0, act1, idle_obs;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign act0 = {rdy0, op0, idx0, iri0, irj0, boe0, bus0, alu0, mov0, ldsr0, ill0, tmo0};
  assign act1 = {rdy1, op1, idx1, iri1, irj1, boe1, bus1, alu1, mov1, ldsr1, ill1, tmo1};

  always #5 clk = ~clk;

  seq_decoder #(.IMM_SIGN_EXT(0), .TIMEOUT(T)) u_zext (
    .clk(clk), .reset(reset), .ir_load(ir_load), .instruction(instruction),
    .ready(rdy0), .op_code(op0), .index(idx0), .iri_en(iri0), .irj_en(irj0),
    .bus_oe(boe0), .bus_out(bus0), .alu_start(alu0), .mov_start(mov0),
    .ldsr_start(ldsr0), .exec_done(exec_done), .illegal(ill0), .timeout(tmo0)
  );

  seq_decoder #(.IMM_SIGN_EXT(1), .TIMEOUT(T)) u_sext (
    .clk(clk), .reset(reset), .ir_load(ir_load), .instruction(instruction),
    .ready(rdy1), .op_code(op1), .index(idx1), .iri_en(iri1), .irj_en(irj1),
    .bus_oe(boe1), .bus_out(bus1), .alu_start(alu1), .mov_start(mov1),
    .ldsr_start(ldsr1), .exec_done(exec_done), .illegal(ill1), .timeout(tmo1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the accepting edge. done_k is the WAIT cycle
  // (1-based) in which exec_done is high; anything outside 1..T means never.
  function automatic obs_t model(input logic [15:0] instr, input int k,
                                 input int done_k, input bit sext);
    obs_t e;
    int   op, fi, fj, w;
    bit   to;
    e  = '0;
    op = int'(instr[15:12]);
    fi = int'(instr[11:6]);
    fj = int'(instr[5:0]);
    if (op > 8) begin
      if (k == 1) begin
        e.op  = 4'(op);
        e.ill = 1'b1;
      end else begin
        e.ready = 1'b1;
      end
      return e;
    end
    to = !(done_k >= 1 && done_k <= T);
    w  = to ? T : done_k;
    if (k > 4 + w) begin
      e.ready = 1'b1;
      return e;
    end
    e.op = 4'(op);
    if (k == 2) begin
      e.iri = 1'b1;
      e.idx = 4'(fi % 16);
    end
    if (k == 3) begin
      if (op == 7) begin
        e.boe = 1'b1;
        e.bus = (sext && fj >= 32) ? 16'(fj - 64) : 16'(fj);
      end else begin
        e.irj = 1'b1;
        e.idx = 4'(fj % 16);
      end
    end
    if (k == 4) begin
      e.alu  = (op <= 5) || (op == 7);
      e.mov  = (op == 6);
      e.ldsr = (op == 8);
    end
    if (k == 4 + w && to) e.tmo = 1'b1;
    return e;
  endfunction

  // mode 0: quiet; 1: random ir_load/exec_done noise where they must be ignored;
  // 2: ir_load held high throughout (back-to-back issue).
  task automatic drive_txn(input logic [15:0] instr, input int done_k,
                           input int mode, input string name);
    int   last;
    obs_t e0, e1;
    ir_load     = 1'b1;
    instruction = instr;
    exec_done   = 1'b0;
    step();
    if (instr[15:12] > 4'd8) last = 1;
    else last = 4 + ((done_k >= 1 && done_k <= T) ? done_k : T);
    for (int k = 1; k <= last + 1; k++) begin
      if (mode == 2) begin
        ir_load     = 1'b1;
        instruction = 16'($urandom);
      end else if (mode == 1 && k <= last) begin
        ir_load     = 1'($urandom_range(0, 1));
        instruction = 16'($urandom);
      end else begin
        ir_load = 1'b0;
      end
      if (k >= 5 && k <= last && instr[15:12] <= 4'd8) exec_done = (k - 4 == done_k);
      else if (mode == 1 && k <= last) exec_done = 1'($urandom_range(0, 1));
      else exec_done = 1'b0;
      e0 = model(instr, k, done_k, 1'b0);
      e1 = model(instr, k, done_k, 1'b1);
      n_cmp++;
      if (act0 !== e0) begin
        n_bad++;
        $display("FAIL %s zext k=%0d got=%h exp=%h", name, k, act0, e0);
      end
      n_cmp++;
      if (act1 !== e1) begin
        n_bad++;
        $display("FAIL %s sext k=%0d got=%h exp=%h", name, k, act1, e1);
      end
      if (k <= last) step();
    end
    exec_done = 1'b0;
    if (mode != 2) ir_load = 1'b0;
    $display("txn %s instr=%h done_k=%0d cycles=%0d", name, instr, done_k, last + 1);
  endtask

  task automatic test_reset;
    reset = 1'b1; ir_load = 1'b0; exec_done = 1'b0; instruction = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (act0 !== idle_obs || act1 !== idle_obs) begin
        n_bad++;
        $display("FAIL reset_init got=%h/%h exp=%h", act0, act1, idle_obs);
      end
    end
    reset = 1'b0;
    // Reset for two cycles in the middle of WAIT.
    ir_load = 1'b1; instruction = {4'd8, 6'd1, 6'd2};
    step();
    ir_load = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (rdy0 !== 1'b0 || op0 !== 4'd8) begin
      n_bad++;
      $display("FAIL reset_pre_wait got ready=%b op=%h exp ready=0 op=8", rdy0, op0);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (act0 !== idle_obs || act1 !== idle_obs) begin
        n_bad++;
        $display("FAIL reset_wait got=%h/%h exp=%h", act0, act1, idle_obs);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (act0 !== idle_obs || act1 !== idle_obs) begin
        n_bad++;
        $display("FAIL reset_release c=%0d got=%h/%h exp=%h", i, act0, act1, idle_obs);
      end
    end
    // Reset while in OPB: the start pulse that would follow must never appear.
    ir_load = 1'b1; instruction = {4'd2, 6'd4, 6'd5};
    step();
    ir_load = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (act0 !== idle_obs || act1 !== idle_obs) begin
        n_bad++;
        $display("FAIL reset_opb c=%0d got=%h/%h exp=%h", i, act0, act1, idle_obs);
      end
      step();
    end
    $display("txn reset sequences done");
  endtask

  task automatic test_addi_zext;
    drive_txn({4'd7, 6'd0, 6'd10}, 1, 0, "addi_zext");
  endtask

  task automatic test_addi_sext;
    drive_txn({4'd7, 6'd9, 6'b111110}, 2, 0, "addi_sext");
  endtask

  task automatic test_mov;
    drive_txn({4'd6, 6'd3, 6'd5}, 3, 0, "mov");
  endtask

  task automatic test_illegal;
    drive_txn({4'd12, 6'd7, 6'd7}, 1, 1, "illegal");
  endtask

  task automatic test_timeout;
    drive_txn({4'd8, 6'd2, 6'd4}, 0, 1, "ldsr_timeout");
  endtask

  task automatic test_back_to_back;
    drive_txn({4'd1, 6'd17, 6'd33}, 1, 2, "b2b_a");
    drive_txn({4'd9, 6'd0, 6'd0}, 1, 2, "b2b_b");
    drive_txn({4'd7, 6'd5, 6'd40}, 4, 2, "b2b_c");
    ir_load = 1'b0;
  endtask

  task automatic test_random;
    logic [15:0] instr;
    int          dk;
    for (int n = 0; n < 40; n++) begin
      instr = 16'($urandom);
      dk    = $urandom_range(0, T + 3);
      // Done exactly on the expiry cycle is left undefined by the design intent.
      if (dk == T) dk = T - 1;
      drive_txn(instr, dk, int'($urandom_range(0, 2)), "random");
    end
    ir_load = 1'b0;
  endtask

  initial begin
    idle_obs       = '0;
    idle_obs.ready = 1'b1;
    fork
      begin
        test_reset();
        test_addi_zext();
        test_addi_sext();
        test_mov();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_random();
      end
      begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
